// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state encoding and defaults for the core control sequencer
package core_ctrl_pkg;

  // One state per instruction phase plus the two terminal conditions.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // Maximum consecutive un-acked request cycles before a bus error.
  localparam int DEFAULT_MEM_TIMEOUT = 15;

  // FETCH and MEM are the only states that wait on a memory acknowledge.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - wait-cycle counter shared by the fetch and data-access waits
module seq_wait_timer
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] count;

  // Count un-acked cycles of the current wait; cleared whenever no wait is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !expire) begin
      count <= count + 1'b1;
    end
  end

  // Raised during the cycle whose missing ack would bring the count to MEM_TIMEOUT,
  // so the sequencer can leave for ERR right after the last allowed request cycle.
  assign expire = (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle IF/ID/EX/MEM/WB controller with run, halt, step and bus timeout
module stage_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_en,
  input  logic            step_req,
  input  logic            halt_req,
  input  logic            is_mem_op,
  input  logic            is_halt_ins,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            dmem_req,
  input  logic            dmem_ack,
  output logic            if_en,
  output logic            id_en,
  output logic            ex_en,
  output logic            mem_en,
  output logic            wb_en,
  output logic            pc_en,
  output logic            halted,
  output logic            bus_err,
  output logic [XLEN-1:0] instr_count
);

  state_t state;
  state_t state_nxt;
  logic   waiting;
  logic   wait_ack;
  logic   tmr_expire;

  // An ack only counts while its own request is outstanding.
  assign waiting  = is_wait_state(state);
  assign wait_ack = ((state == S_FETCH) && imem_ack) || ((state == S_MEM) && dmem_ack);

  seq_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!waiting),
    .inc    (waiting && !wait_ack),
    .expire (tmr_expire)
  );

  // State register; reset drops every request immediately through the Moore decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection and per-state output decode.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    if_en     = 1'b0;
    id_en     = 1'b0;
    ex_en     = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    pc_en     = 1'b0;
    halted    = 1'b0;
    bus_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (halt_req) begin
          state_nxt = S_HALT;
        end else if (run_en || step_req) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if_en    = imem_ack;
        if (imem_ack) begin
          state_nxt = S_DECODE;
        end else if (tmr_expire) begin
          state_nxt = S_ERR;
        end
      end
      S_DECODE: begin
        id_en     = 1'b1;
        // EBREAK stops here so the PC still points at it.
        state_nxt = is_halt_ins ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        ex_en     = 1'b1;
        state_nxt = is_mem_op ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        mem_en   = dmem_ack;
        if (dmem_ack) begin
          state_nxt = S_WB;
        end else if (tmr_expire) begin
          state_nxt = S_ERR;
        end
      end
      S_WB: begin
        wb_en = 1'b1;
        pc_en = 1'b1;
        if (halt_req) begin
          state_nxt = S_HALT;
        end else if (run_en) begin
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (step_req) begin
          state_nxt = S_FETCH;
        end
      end
      S_ERR: begin
        bus_err = 1'b1;
      end
    endcase
  end

  // Retired-instruction counter, bumped once per write-back cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (state == S_WB) begin
      instr_count <= instr_count + 1'b1;
    end
  end

endmodule
